mmio_responder: RTL and testbench

Memory-side target for the uncacheable MMIO region (address tag `addr[31:22] == 10'h1`, i.e. 0x0040_0000–0x007F_FFFF). It is the responder end of the uncached request path: it accepts one single-beat read or write at a time and returns one response per request. Accesses that fall outside its register window return an error response. It hosts two scratch registers, a 64-bit machine timer with compare, a control register and a read-only ID, and drives the timer interrupt to the core.

---
 rtl/mmio_pkg.sv | 40 ++++
 rtl/mmio_timer.sv | 61 ++++++
 rtl/mmio_responder.sv | 139 +++++++++++++
 tb/tb_mmio_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants, types and helpers for the uncached MMIO responder.
package mmio_pkg;

  // Address tag selecting the MMIO region 0x0040_0000 - 0x007F_FFFF
  localparam logic [9:0] MMIO_TAG = 10'h001;

  // Register offsets within the window
  localparam logic [21:0] OFF_SCRATCH0    = 22'h00_0000;
  localparam logic [21:0] OFF_SCRATCH1    = 22'h00_0004;
  localparam logic [21:0] OFF_MTIME_LO    = 22'h00_0008;
  localparam logic [21:0] OFF_MTIME_HI    = 22'h00_000C;
  localparam logic [21:0] OFF_MTIMECMP_LO = 22'h00_0010;
  localparam logic [21:0] OFF_MTIMECMP_HI = 22'h00_0014;
  localparam logic [21:0] OFF_CTRL        = 22'h00_0018;
  localparam logic [21:0] OFF_ID          = 22'h00_001C;

  // Value reported by the ID register unless overridden
  localparam logic [31:0] DEFAULT_ID = 32'h5256_3332;

  // Responder handshake state
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Byte-lane merge: strobed lanes take new data, others keep old data
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// 64-bit machine timer with compare; byte-strobed word writes, free-running
// increment while enabled, and a level interrupt on MTIME >= MTIMECMP.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        mtime_lo_we_i,
  input  logic        mtime_hi_we_i,
  input  logic        cmp_lo_we_i,
  input  logic        cmp_hi_we_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o,
  output logic        irq_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q,   cmp_d;

  // Next MTIME/MTIMECMP: a bus write to either MTIME word wins over the
  // increment for that cycle and leaves the other word untouched
  always_comb begin
    mtime_d = mtime_q;
    cmp_d   = cmp_q;
    if (mtime_lo_we_i) begin
      mtime_d[31:0] = merge_bytes(mtime_q[31:0], wdata_i, wstrb_i);
    end else if (mtime_hi_we_i) begin
      mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdata_i, wstrb_i);
    end else if (en_i) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end
    if (cmp_lo_we_i) begin
      cmp_d[31:0] = merge_bytes(cmp_q[31:0], wdata_i, wstrb_i);
    end else if (cmp_hi_we_i) begin
      cmp_d[63:32] = merge_bytes(cmp_q[63:32], wdata_i, wstrb_i);
    end else begin
      cmp_d = cmp_q;
    end
  end

  // Timer state registers; compare resets to all ones so no early interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= 64'h0;
      cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
    end
  end

  assign mtime_o    = mtime_q;
  assign mtimecmp_o = cmp_q;
  assign irq_o      = en_i && (mtime_q >= cmp_q);

endmodule

// File: rtl/mmio_responder.sv
// Single-outstanding MMIO target: decodes one request at a time, performs
// the access on the accept edge and holds the response until it is taken.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = DEFAULT_ID
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        timer_irq
);

  state_e      state_q, state_d;
  logic [31:0] scratch0_q, scratch0_d;
  logic [31:0] scratch1_q, scratch1_d;
  logic        ctrl_en_q,  ctrl_en_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q,   rsp_err_d;

  logic [21:0] offset_s;
  logic        accept_s;
  logic        addr_err_s;
  logic        wr_ok_s;
  logic [31:0] rd_mux_s;
  logic [63:0] mtime_s;
  logic [63:0] mtimecmp_s;

  assign offset_s   = req_addr[21:0];
  assign accept_s   = req_valid && (state_q == IDLE);
  assign addr_err_s = (req_addr[31:22] != MMIO_TAG) ||
                      (req_addr[1:0] != 2'b00) ||
                      (offset_s > OFF_ID) ||
                      (req_we && (offset_s == OFF_ID));
  assign wr_ok_s    = accept_s && req_we && !addr_err_s;

  // Read data selection from current (pre-update) register state
  always_comb begin
    rd_mux_s = 32'h0;
    case (offset_s)
      OFF_SCRATCH0:    rd_mux_s = scratch0_q;
      OFF_SCRATCH1:    rd_mux_s = scratch1_q;
      OFF_MTIME_LO:    rd_mux_s = mtime_s[31:0];
      OFF_MTIME_HI:    rd_mux_s = mtime_s[63:32];
      OFF_MTIMECMP_LO: rd_mux_s = mtimecmp_s[31:0];
      OFF_MTIMECMP_HI: rd_mux_s = mtimecmp_s[63:32];
      OFF_CTRL:        rd_mux_s = {31'h0, ctrl_en_q};
      OFF_ID:          rd_mux_s = ID_VALUE;
      default:         rd_mux_s = 32'h0;
    endcase
  end

  // FSM, local register writes and response capture
  always_comb begin
    state_d     = state_q;
    scratch0_d  = scratch0_q;
    scratch1_d  = scratch1_q;
    ctrl_en_d   = ctrl_en_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d     = RESP;
          rsp_err_d   = addr_err_s;
          rsp_rdata_d = (req_we || addr_err_s) ? 32'h0 : rd_mux_s;
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_ok_s && (offset_s == OFF_SCRATCH0)) begin
      scratch0_d = merge_bytes(scratch0_q, req_wdata, req_wstrb);
    end else if (wr_ok_s && (offset_s == OFF_SCRATCH1)) begin
      scratch1_d = merge_bytes(scratch1_q, req_wdata, req_wstrb);
    end else if (wr_ok_s && (offset_s == OFF_CTRL) && req_wstrb[0]) begin
      ctrl_en_d = req_wdata[0];
    end else begin
      ctrl_en_d = ctrl_en_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      scratch0_q  <= 32'h0;
      scratch1_q  <= 32'h0;
      ctrl_en_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      scratch0_q  <= scratch0_d;
      scratch1_q  <= scratch1_d;
      ctrl_en_q   <= ctrl_en_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  mmio_timer u_timer (
    .clk           (clk),
    .rst           (rst),
    .en_i          (ctrl_en_q),
    .mtime_lo_we_i (wr_ok_s && (offset_s == OFF_MTIME_LO)),
    .mtime_hi_we_i (wr_ok_s && (offset_s == OFF_MTIME_HI)),
    .cmp_lo_we_i   (wr_ok_s && (offset_s == OFF_MTIMECMP_LO)),
    .cmp_hi_we_i   (wr_ok_s && (offset_s == OFF_MTIMECMP_HI)),
    .wdata_i       (req_wdata),
    .wstrb_i       (req_wstrb),
    .mtime_o       (mtime_s),
    .mtimecmp_o    (mtimecmp_s),
    .irq_o         (timer_irq)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wstrb = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        timer_irq;

  int total = 0;
  int bad   = 0;

  // values observed by the last access (negedge after accept)
  logic [31:0] r_data;
  logic        r_err, r_vld, r_rdy, r_irq;

  mmio_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  // One request/response; starts and ends just after a falling edge.
  task automatic access(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
    int waits;
    waits = 0;
    while (!req_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL access_wait req_ready=%0b required=1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_wdata = wdata; req_wstrb = strb;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    r_data = rsp_rdata; r_err = rsp_err; r_vld = rsp_valid;
    r_rdy = req_ready; r_irq = timer_irq;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%0b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0b exp=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%0b exp=0", rsp_err); end
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%0b exp=0", timer_irq); end
  endtask

  task automatic test_scratch();
    access(1'b1, 32'h0040_0000, 32'hDEAD_BEEF, 4'hF);
    total++; if (r_err !== 1'b0 || r_data !== 32'h0 || r_vld !== 1'b1 || r_rdy !== 1'b0) begin
      bad++; $display("FAIL scratch_wr err=%0b data=%h vld=%0b rdy=%0b exp 0/0/1/0", r_err, r_data, r_vld, r_rdy);
    end
    access(1'b0, 32'h0040_0000, 32'h0, 4'h0);
    total++; if (r_err !== 1'b0 || r_data !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL scratch_rd err=%0b data=%h exp 0/deadbeef", r_err, r_data);
    end
  endtask

  task automatic test_strobes();
    access(1'b1, 32'h0040_0004, 32'hFFFF_FFFF, 4'hF);
    access(1'b1, 32'h0040_0004, 32'h1234_5678, 4'b0101);
    access(1'b0, 32'h0040_0004, 32'h0, 4'h0);
    total++; if (r_data !== 32'hFF34_FF78) begin bad++; $display("FAIL strobe_merge got=%h exp=ff34ff78", r_data); end
    access(1'b1, 32'h0040_0004, 32'hAAAA_AAAA, 4'h0);
    total++; if (r_err !== 1'b0) begin bad++; $display("FAIL strobe_zero_err got=%0b exp=0", r_err); end
    access(1'b0, 32'h0040_0004, 32'h0, 4'h0);
    total++; if (r_data !== 32'hFF34_FF78) begin bad++; $display("FAIL strobe_zero_data got=%h exp=ff34ff78", r_data); end
  endtask

  task automatic test_errors();
    access(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    total++; if (r_err !== 1'b1 || r_data !== 32'h0) begin bad++; $display("FAIL err_tag err=%0b data=%h exp 1/0", r_err, r_data); end
    access(1'b0, 32'h0040_0002, 32'h0, 4'h0);
    total++; if (r_err !== 1'b1 || r_data !== 32'h0) begin bad++; $display("FAIL err_misalign err=%0b data=%h exp 1/0", r_err, r_data); end
    access(1'b0, 32'h0040_0020, 32'h0, 4'h0);
    total++; if (r_err !== 1'b1 || r_data !== 32'h0) begin bad++; $display("FAIL err_range err=%0b data=%h exp 1/0", r_err, r_data); end
    access(1'b1, 32'h0040_001C, 32'h1111_1111, 4'hF);
    total++; if (r_err !== 1'b1) begin bad++; $display("FAIL err_id_write err=%0b exp=1", r_err); end
    access(1'b0, 32'h0040_001C, 32'h0, 4'h0);
    total++; if (r_err !== 1'b0 || r_data !== 32'h5256_3332) begin bad++; $display("FAIL id_read err=%0b data=%h exp 0/52563332", r_err, r_data); end
    access(1'b1, 32'h0040_0000, 32'h7777_7777, 4'hF);
    access(1'b1, 32'h0080_0000, 32'h9999_9999, 4'hF);
    access(1'b0, 32'h0040_0000, 32'h0, 4'h0);
    total++; if (r_data !== 32'h7777_7777) begin bad++; $display("FAIL err_no_write got=%h exp=77777777", r_data); end
  endtask

  task automatic test_timer();
    access(1'b1, 32'h0040_0014, 32'h0, 4'hF);
    access(1'b1, 32'h0040_0010, 32'd10, 4'hF);
    access(1'b1, 32'h0040_0018, 32'h1, 4'hF);
    // MTIME is 1 here; 8 more edges -> 9, one more -> 10
    repeat (8) @(posedge clk);
    @(negedge clk);
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL irq_at_9 got=%0b exp=0", timer_irq); end
    @(posedge clk);
    @(negedge clk);
    total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL irq_at_10 got=%0b exp=1", timer_irq); end
    access(1'b1, 32'h0040_0010, 32'hFFFF_FFFF, 4'hF);
    total++; if (r_irq !== 1'b0) begin bad++; $display("FAIL irq_drop got=%0b exp=0", r_irq); end
    access(1'b0, 32'h0040_0018, 32'h0, 4'h0);
    total++; if (r_data !== 32'h1) begin bad++; $display("FAIL ctrl_read got=%h exp=1", r_data); end
  endtask

  task automatic test_wrap();
    apply_reset();
    access(1'b1, 32'h0040_0008, 32'hFFFF_FFFE, 4'hF);
    access(1'b1, 32'h0040_000C, 32'hFFFF_FFFF, 4'hF);
    access(1'b1, 32'h0040_0018, 32'h1, 4'hF);
    // MTIME is all ones, equal to the reset compare value
    total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL wrap_irq_max got=%0b exp=1", timer_irq); end
    access(1'b0, 32'h0040_0008, 32'h0, 4'h0);
    total++; if (r_data !== 32'hFFFF_FFFF || r_irq !== 1'b0) begin
      bad++; $display("FAIL wrap_lo_pre data=%h irq=%0b exp ffffffff/0", r_data, r_irq);
    end
    access(1'b0, 32'h0040_000C, 32'h0, 4'h0);
    total++; if (r_data !== 32'h0) begin bad++; $display("FAIL wrap_hi got=%h exp=0", r_data); end
    access(1'b0, 32'h0040_0008, 32'h0, 4'h0);
    total++; if (r_data !== 32'd3) begin bad++; $display("FAIL wrap_lo_count got=%h exp=3", r_data); end
    // HI write collides with an increment: LO must not advance that cycle
    access(1'b1, 32'h0040_000C, 32'h0000_00A5, 4'hF);
    access(1'b0, 32'h0040_0008, 32'h0, 4'h0);
    total++; if (r_data !== 32'd6) begin bad++; $display("FAIL collide_lo got=%h exp=6", r_data); end
    access(1'b0, 32'h0040_000C, 32'h0, 4'h0);
    total++; if (r_data !== 32'h0000_00A5) begin bad++; $display("FAIL collide_hi got=%h exp=a5", r_data); end
  endtask

  task automatic test_backpressure_reset();
    access(1'b1, 32'h0040_0000, 32'h0BAD_F00D, 4'hF);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0040_0000; req_wstrb = 4'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D || rsp_err !== 1'b0) begin
        bad++; $display("FAIL hold_%0d vld=%0b rdy=%0b data=%h err=%0b exp 1/0/0badf00d/0", i, rsp_valid, req_ready, rsp_rdata, rsp_err);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL mid_rst vld=%0b rdy=%0b data=%h exp 0/1/0", rsp_valid, req_ready, rsp_rdata);
    end
    access(1'b0, 32'h0040_0000, 32'h0, 4'h0);
    total++; if (r_data !== 32'h0) begin bad++; $display("FAIL rst_scratch0 got=%h exp=0", r_data); end
    access(1'b0, 32'h0040_0014, 32'h0, 4'h0);
    total++; if (r_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp_hi got=%h exp=ffffffff", r_data); end
    access(1'b0, 32'h0040_0008, 32'h0, 4'h0);
    total++; if (r_data !== 32'h0) begin bad++; $display("FAIL rst_mtime_lo got=%h exp=0", r_data); end
    access(1'b0, 32'h0040_0018, 32'h0, 4'h0);
    total++; if (r_data !== 32'h0) begin bad++; $display("FAIL rst_ctrl got=%h exp=0", r_data); end
  endtask

  initial begin
    test_reset();
    test_scratch();
    test_strobes();
    test_errors();
    test_timer();
    test_wrap();
    test_backpressure_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
